// File: rtl/fpu_cvt_wb_pkg.sv
// Shared types for the FPU conversion writeback buffer: slot record, register bundle, oldest-match search.
// Struct widths follow the *_P constants; change them here when resizing the buffer.
package fpu_cvt_wb_pkg;

  localparam int NUNITS_P = 2;
  localparam int DEPTH_P  = 4;
  localparam int RES_W_P  = 64;
  localparam int IDX_W    = $clog2(DEPTH_P);
  localparam int CNT_W    = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2
  } slot_state_e;

  typedef struct packed {
    slot_state_e        state;
    logic [1:0]         unit;
    logic [5:0]         rd;
    logic [RES_W_P-1:0] res;
  } slot_t;

  typedef slot_t [DEPTH_P-1:0] slot_arr_t;

  typedef struct packed {
    slot_arr_t        slots;
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } regs_t;

  localparam regs_t REGS_RST = '0;

  // Returns {found, index} of the PEND slot for this unit closest to rptr, walking forward with wrap.
  function automatic logic [IDX_W:0] find_oldest_pend(input slot_arr_t        slots,
                                                      input logic [IDX_W-1:0] rptr,
                                                      input logic [1:0]       unit);
    logic [IDX_W:0]   hit;
    logic [IDX_W-1:0] idx;
    hit = '0;
    for (int i = DEPTH_P - 1; i >= 0; i--) begin
      idx = rptr + IDX_W'(i);
      if (slots[idx].state == ST_PEND && slots[idx].unit == unit) begin
        hit = {1'b1, idx};
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/fpu_cvt_wb.sv
// In-order writeback buffer for multi-cycle FPU conversion units: tracks issued conversions,
// captures their result pulses and hands them to writeback in issue order over valid/ready.
module fpu_cvt_wb
  import fpu_cvt_wb_pkg::*;
#(
  parameter int NUNITS = NUNITS_P,
  parameter int DEPTH  = DEPTH_P,
  parameter int RES_W  = RES_W_P
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_issue,
  input  logic [1:0]              i_unit,
  input  logic [5:0]              i_rd,
  output logic                    o_issue_ready,
  input  logic [NUNITS-1:0]       i_res_valid,
  input  logic [NUNITS*RES_W-1:0] i_res,
  output logic                    o_wb_valid,
  output logic [5:0]              o_wb_rd,
  output logic [RES_W-1:0]        o_wb_res,
  input  logic                    i_wb_ready,
  output logic                    o_err,
  output logic [CNT_W-1:0]        o_cnt
);

  regs_t          r;
  regs_t          rin;
  logic           accept;
  logic           pop;
  logic [IDX_W:0] hit;

  assign o_issue_ready = (r.cnt < CNT_W'(DEPTH));
  assign o_wb_valid    = (r.slots[r.rptr].state == ST_DONE);
  assign o_wb_rd       = r.slots[r.rptr].rd;
  assign o_wb_res      = r.slots[r.rptr].res;
  assign o_err         = r.err;
  assign o_cnt         = r.cnt;

  always_comb begin : comb_proc
    rin    = r;
    hit    = '0;
    accept = i_issue && o_issue_ready;
    pop    = o_wb_valid && i_wb_ready;

    if (pop) begin
      rin.slots[r.rptr].state = ST_FREE;
      rin.rptr                = r.rptr + IDX_W'(1);
    end

    // Matching looks only at registered state, so a slot accepted this cycle cannot be hit.
    for (int u = 0; u < NUNITS; u++) begin
      if (i_res_valid[u]) begin
        hit = find_oldest_pend(r.slots, r.rptr, 2'(u));
        if (hit[IDX_W]) begin
          rin.slots[hit[IDX_W-1:0]].state = ST_DONE;
          rin.slots[hit[IDX_W-1:0]].res   = i_res[u*RES_W +: RES_W];
        end else begin
          rin.err = 1'b1;
        end
      end
    end

    if (accept) begin
      rin.slots[r.wptr].state = ST_PEND;
      rin.slots[r.wptr].unit  = i_unit;
      rin.slots[r.wptr].rd    = i_rd;
      rin.wptr                = r.wptr + IDX_W'(1);
    end

    case ({accept, pop})
      2'b10:   rin.cnt = r.cnt + CNT_W'(1);
      2'b01:   rin.cnt = r.cnt - CNT_W'(1);
      default: rin.cnt = r.cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin : rg_proc
    if (!i_nrst) begin
      r <= REGS_RST;
    end else begin
      r <= rin;
    end
  end

endmodule
